// File: rtl/wasm_operand_stack.sv
// Operand stack for the WebAssembly core: PUSH, POP, fused BINOP (pop two, push one) with sticky traps.
// Optional `second` output (entry below top) is enabled by defining OPSTACK_SECOND_EN.
module wasm_operand_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   op,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             top,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef OPSTACK_SECOND_EN
    output logic [WIDTH-1:0]             second,
`endif
    output logic [2:0]                   trap
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_PUSH  = 2'd1;
    localparam logic [1:0] OP_POP   = 2'd2;
    localparam logic [1:0] OP_BINOP = 2'd3;

    localparam logic [2:0] TRAP_NONE      = 3'd0;
    localparam logic [2:0] TRAP_OVERFLOW  = 3'd4;
    localparam logic [2:0] TRAP_UNDERFLOW = 3'd5;

    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] top_r;
    logic [WIDTH-1:0] second_r;
    logic [2:0]       trap_r;
    logic             empty_r;
    logic             full_r;

    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] top_nxt_s;
    logic [WIDTH-1:0] second_nxt_s;
    logic [2:0]       trap_nxt_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    third_idx_s;
    logic [WIDTH-1:0] third_s;

    // Entry two below the top; becomes the new `second` after POP or BINOP.
    always_comb begin
        third_idx_s = count_r[AW-1:0] - AW'(3);
        if (count_r >= CW'(3)) begin
            third_s = mem_r[third_idx_s];
        end else begin
            third_s = '0;
        end
    end

    // Next-state decode; top/second are kept as shadow registers so outputs stay registered.
    always_comb begin
        count_nxt_s  = count_r;
        top_nxt_s    = top_r;
        second_nxt_s = second_r;
        trap_nxt_s   = trap_r;
        wr_en_s      = 1'b0;
        wr_idx_s     = '0;
        if (trap_r == TRAP_NONE) begin
            case (op)
                OP_NOP: begin
                    count_nxt_s = count_r;
                end
                OP_PUSH: begin
                    if (full_r) begin
                        trap_nxt_s = TRAP_OVERFLOW;
                    end else begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = count_r[AW-1:0];
                        count_nxt_s  = count_r + CW'(1);
                        top_nxt_s    = data_in;
                        second_nxt_s = top_r;
                    end
                end
                OP_POP: begin
                    if (empty_r) begin
                        trap_nxt_s = TRAP_UNDERFLOW;
                    end else begin
                        count_nxt_s  = count_r - CW'(1);
                        top_nxt_s    = second_r;
                        second_nxt_s = third_s;
                    end
                end
                OP_BINOP: begin
                    if (count_r < CW'(2)) begin
                        trap_nxt_s = TRAP_UNDERFLOW;
                    end else begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = count_r[AW-1:0] - AW'(2);
                        count_nxt_s  = count_r - CW'(1);
                        top_nxt_s    = data_in;
                        second_nxt_s = third_s;
                    end
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end else begin
            trap_nxt_s = trap_r;
        end
    end

    // Storage array; contents are don't-care after reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= data_in;
        end
    end

    // Stack pointer, shadow top/second, flags and sticky trap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= '0;
            top_r    <= '0;
            second_r <= '0;
            trap_r   <= TRAP_NONE;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            top_r    <= top_nxt_s;
            second_r <= second_nxt_s;
            trap_r   <= trap_nxt_s;
            empty_r  <= (count_nxt_s == CW'(0));
            full_r   <= (count_nxt_s == CW'(DEPTH));
        end
    end

    assign top   = top_r;
    assign empty = empty_r;
    assign full  = full_r;
    assign count = count_r;
    assign trap  = trap_r;
`ifdef OPSTACK_SECOND_EN
    assign second = second_r;
`endif

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Directed self-checking bench for wasm_operand_stack (WIDTH 64, DEPTH 4).
module tb_wasm_operand_stack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [63:0] data_in = 64'd0;
    logic [63:0] top;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic [2:0]  trap;
`ifdef OPSTACK_SECOND_EN
    logic [63:0] second;
`endif

    int checks = 0;
    int failures = 0;

    wasm_operand_stack #(.WIDTH(64), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .data_in (data_in),
        .top     (top),
        .empty   (empty),
        .full    (full),
        .count   (count),
`ifdef OPSTACK_SECOND_EN
        .second  (second),
`endif
        .trap    (trap)
    );

    always #5 clk = ~clk;

    task automatic do_op(input logic [1:0] o, input logic [63:0] d);
        @(negedge clk);
        op = o;
        data_in = d;
        @(posedge clk);
        #1;
        op = 2'd0;
        data_in = 64'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        op = 2'd1;
        data_in = 64'd99;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 3'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1)  begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0)   begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (top !== 64'd0)   begin failures++; $display("FAIL reset_top got=%0h exp=0", top); end
        checks++; if (trap !== 3'd0)   begin failures++; $display("FAIL reset_trap got=%0d exp=0", trap); end
`ifdef OPSTACK_SECOND_EN
        checks++; if (second !== 64'd0) begin failures++; $display("FAIL reset_second got=%0h exp=0", second); end
`endif
        op = 2'd0;
        data_in = 64'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_push_binop();
        apply_reset();
        do_op(2'd1, 64'd5);
`ifdef OPSTACK_SECOND_EN
        checks++; if (second !== 64'd0) begin failures++; $display("FAIL pb_second_one got=%0h exp=0", second); end
`endif
        do_op(2'd1, 64'd7);
        checks++; if (top !== 64'd7)   begin failures++; $display("FAIL pb_top got=%0h exp=7", top); end
        checks++; if (count !== 3'd2)  begin failures++; $display("FAIL pb_count got=%0d exp=2", count); end
`ifdef OPSTACK_SECOND_EN
        checks++; if (second !== 64'd5) begin failures++; $display("FAIL pb_second got=%0h exp=5", second); end
`endif
        do_op(2'd3, 64'd12);
        checks++; if (top !== 64'd12)  begin failures++; $display("FAIL binop_top got=%0h exp=c", top); end
        checks++; if (count !== 3'd1)  begin failures++; $display("FAIL binop_count got=%0d exp=1", count); end
        checks++; if (empty !== 1'b0)  begin failures++; $display("FAIL binop_empty got=%0b exp=0", empty); end
        checks++; if (trap !== 3'd0)   begin failures++; $display("FAIL binop_trap got=%0d exp=0", trap); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            do_op(2'd1, 64'(i));
        end
        checks++; if (full !== 1'b1)   begin failures++; $display("FAIL fill_full got=%0b exp=1", full); end
        checks++; if (count !== 3'd4)  begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (empty !== 1'b0)  begin failures++; $display("FAIL fill_empty got=%0b exp=0", empty); end
`ifdef OPSTACK_SECOND_EN
        checks++; if (second !== 64'd3) begin failures++; $display("FAIL fill_second got=%0h exp=3", second); end
`endif
        do_op(2'd1, 64'd9);
        checks++; if (trap !== 3'd4)   begin failures++; $display("FAIL ovf_trap got=%0d exp=4", trap); end
        checks++; if (top !== 64'd4)   begin failures++; $display("FAIL ovf_top got=%0h exp=4", top); end
        checks++; if (count !== 3'd4)  begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
        do_op(2'd2, 64'd0);
        checks++; if (count !== 3'd4)  begin failures++; $display("FAIL frozen_count got=%0d exp=4", count); end
        checks++; if (trap !== 3'd4)   begin failures++; $display("FAIL frozen_trap got=%0d exp=4", trap); end
    endtask

    task automatic test_underflow();
        apply_reset();
        do_op(2'd2, 64'd0);
        checks++; if (trap !== 3'd5)   begin failures++; $display("FAIL unf_pop_trap got=%0d exp=5", trap); end
        checks++; if (count !== 3'd0)  begin failures++; $display("FAIL unf_pop_count got=%0d exp=0", count); end
        do_op(2'd1, 64'd3);
        checks++; if (count !== 3'd0)  begin failures++; $display("FAIL unf_frozen_count got=%0d exp=0", count); end
        apply_reset();
        do_op(2'd1, 64'd1);
        do_op(2'd3, 64'd77);
        checks++; if (trap !== 3'd5)   begin failures++; $display("FAIL unf_binop_trap got=%0d exp=5", trap); end
        checks++; if (top !== 64'd1)   begin failures++; $display("FAIL unf_binop_top got=%0h exp=1", top); end
        checks++; if (count !== 3'd1)  begin failures++; $display("FAIL unf_binop_count got=%0d exp=1", count); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_op(2'd1, 64'd3);
        do_op(2'd1, 64'd6);
        checks++; if (top !== 64'd6)   begin failures++; $display("FAIL ar_pre_top got=%0h exp=6", top); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0)  begin failures++; $display("FAIL ar_count got=%0d exp=0", count); end
        checks++; if (top !== 64'd0)   begin failures++; $display("FAIL ar_top got=%0h exp=0", top); end
        checks++; if (empty !== 1'b1)  begin failures++; $display("FAIL ar_empty got=%0b exp=1", empty); end
        @(negedge clk);
        reset = 1'b1;
        do_op(2'd1, 64'd8);
        checks++; if (top !== 64'd8)   begin failures++; $display("FAIL ar_post_top got=%0h exp=8", top); end
        checks++; if (count !== 3'd1)  begin failures++; $display("FAIL ar_post_count got=%0d exp=1", count); end
    endtask

    task automatic test_eqz_flow();
        apply_reset();
        do_op(2'd1, 64'd0);
        do_op(2'd2, 64'd0);
        checks++; if (empty !== 1'b1)  begin failures++; $display("FAIL eqz_mid_empty got=%0b exp=1", empty); end
        do_op(2'd1, 64'd1);
        checks++; if (top !== 64'd1)   begin failures++; $display("FAIL eqz_top got=%0h exp=1", top); end
        checks++; if (empty !== 1'b0)  begin failures++; $display("FAIL eqz_empty got=%0b exp=0", empty); end
        checks++; if (trap !== 3'd0)   begin failures++; $display("FAIL eqz_trap got=%0d exp=0", trap); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_op(2'd1, 64'hDEAD_BEEF_CAFE_F00D);
        do_op(2'd1, 64'h8000_0000_0000_0001);
        checks++; if (top !== 64'h8000_0000_0000_0001) begin failures++; $display("FAIL b2b_top2 got=%0h exp=8000000000000001", top); end
        do_op(2'd1, 64'h0123_4567_89AB_CDEF);
        do_op(2'd2, 64'd0);
        checks++; if (top !== 64'h8000_0000_0000_0001) begin failures++; $display("FAIL b2b_pop_top got=%0h exp=8000000000000001", top); end
        do_op(2'd2, 64'd0);
        checks++; if (top !== 64'hDEAD_BEEF_CAFE_F00D) begin failures++; $display("FAIL b2b_pop2_top got=%0h exp=deadbeefcafef00d", top); end
        checks++; if (count !== 3'd1)  begin failures++; $display("FAIL b2b_count got=%0d exp=1", count); end
        do_op(2'd2, 64'd0);
        checks++; if (top !== 64'd0)   begin failures++; $display("FAIL b2b_empty_top got=%0h exp=0", top); end
        checks++; if (empty !== 1'b1)  begin failures++; $display("FAIL b2b_empty got=%0b exp=1", empty); end
        checks++; if (trap !== 3'd0)   begin failures++; $display("FAIL b2b_trap got=%0d exp=0", trap); end
    endtask

    initial begin
        test_reset();
        test_push_binop();
        test_fill();
        test_underflow();
        test_async_reset();
        test_eqz_flow();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wasm_operand_stack.md
# wasm_operand_stack

Parametrised operand stack for the WebAssembly CPU core, holding values pushed by constant/load instructions and consumed by unary/binary operators. It generalises the fixed single-result path of the current core to a configurable width and depth, supports a fused pop-two-push-one operation for binary operators, and raises sticky stack traps. It sits between the decoder/ALU and the core's `result`/`result_empty` outputs.

## Interface
- `WIDTH`, 64, bits per stack entry (32 or 64 in use).
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  2  0 NOP, 1 PUSH, 2 POP, 3 BINOP (pop two, push `data_in`).
- `data_in`  in  WIDTH  value for PUSH/BINOP.
- `top`  out  WIDTH  current top entry; 0 when empty.
- `empty`  out  1  no entries.
- `full`  out  1  DEPTH entries.
- `count`  out  $clog2(DEPTH+1)  number of entries.
- `trap`  out  3  0 none, 4 stack overflow, 5 stack underflow; sticky.
- `second`  out  WIDTH  entry below top; 0 when count < 2 (only with `OPSTACK_SECOND_EN`).

## Operation
- Storage: DEPTH×WIDTH register array plus stack pointer `count`; `top` = mem[count-1].
- PUSH: count < DEPTH → mem[count] ← data_in, count+1. count = DEPTH → no write, trap ← 4.
- POP: count ≥ 1 → count-1. count = 0 → trap ← 5.
- BINOP: count ≥ 2 → mem[count-2] ← data_in, count-1. count < 2 → no change, trap ← 5.
- NOP: no change.
- Once `trap` ≠ 0 all further ops are ignored (state frozen) until reset.
- Overflow is checked before underflow; only one trap code is ever latched (first wins).
- `data_in` is taken verbatim; no truncation or sign extension inside the block.

## Timing
- All updates on rising `clk`; `top`, `second`, `empty`, `full`, `count`, `trap` reflect the op one edge after it is presented (registered/derived from registered state, no combinational path from `op`/`data_in`).
- Back-to-back ops every cycle supported; no stall or handshake.
- PUSH then POP on consecutive edges: top returns to previous value the cycle after the POP edge.
- Reset (`reset` low) asynchronously forces count 0, empty 1, full 0, top 0, second 0, trap 0; array contents need not be cleared. Reset asserted mid-sequence discards state immediately; first op sampled is on the first rising edge with `reset` high.
- `full` and `empty` are mutually exclusive for DEPTH ≥ 1.

## Configuration
- `OPSTACK_SECOND_EN` defined: `second` port present, driven mem[count-2] (0 when count < 2), letting the ALU read both binary operands in the same cycle.
- Undefined: `second` port absent; binary operators read operands via successive POPs. All other behaviour identical.

## Test plan
- Reset: hold `reset` low 2 cycles → count 0, empty 1, full 0, top 0, trap 0.
- PUSH 5, PUSH 7 (WIDTH 64, DEPTH 4) → top 7, count 2, second 5 (with macro); then BINOP data_in 12 → top 12, count 1, empty 0.
- Fill: PUSH 1,2,3,4 → full 1, count 4; fifth PUSH 9 → trap 4, top still 4, count 4; later POP ignored, count stays 4.
- Underflow: from reset, POP → trap 5, count 0; separately, one PUSH 1 then BINOP → trap 5, top 1, count 1.
- Async reset mid-stream: after PUSH 3, PUSH 6, drop `reset` between edges → outputs clear before next edge; after release PUSH 8 → top 8, count 1.
- eqz-style flow: PUSH 0, BINOP-free POP then PUSH 1 → top 1, empty 0, trap 0 (matches `result`=1, `result_empty`=0 at core level).
